// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle stage sequencer for the CPU core.
// Drives a one-hot stage_active vector (bit 0 = CONTROL) and advances on per-stage done handshakes.
// It also handles decode-time stage skipping, fault abort with cause capture,
// prioritised interrupts and a double-fault halt.
// Optional feature macro: STAGE_TIMEOUT_EN (per-stage watchdog raising fault code all-ones).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   stage_done      per-stage done (only the active stage's bit is looked at)
//   stage_skip      skip mask from decode, sampled when SKIP_STAGE completes
//   fault/fault_code  abort request from the active stage and its cause
//   irq_pending/irq_enable  level interrupt requests and global enable
//   stage_active    one-hot active stage, zero only when halted
//   control_op      11 normal, 00 trap, 01 ext int, 10 sw int (held for the whole sequence)
//   trap_cause      {is_int, code}
//   irq_ack         one-cycle one-hot acknowledge of the accepted interrupt
//   instr_retired   pulse on return to CONTROL after a normal sequence
//   halted          double-fault halt
module stage_sequencer #(
    parameter int NUM_STAGES  = 7,
    parameter int SKIP_STAGE  = 2,
    parameter int NUM_IRQ     = 4,
    parameter int FAULT_W     = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_STAGES-1:0] stage_done,
    input  logic [NUM_STAGES-1:0] stage_skip,
    input  logic                  fault,
    input  logic [FAULT_W-1:0]    fault_code,
    input  logic [NUM_IRQ-1:0]    irq_pending,
    input  logic                  irq_enable,
    output logic [NUM_STAGES-1:0] stage_active,
    output logic [1:0]            control_op,
    output logic [FAULT_W:0]      trap_cause,
    output logic [NUM_IRQ-1:0]    irq_ack,
    output logic                  instr_retired,
    output logic                  halted
);

    localparam int IDX_W = $clog2(NUM_STAGES);
    // Bits above SKIP_STAGE may be skipped; decode and earlier stages never are.
    localparam logic [NUM_STAGES-1:0] KEEP_MASK =
        ~((NUM_STAGES'(1) << (SKIP_STAGE + 1)) - NUM_STAGES'(1));

    if (NUM_STAGES < 3 || SKIP_STAGE >= NUM_STAGES || TIMEOUT_CYC < 1 ||
        NUM_IRQ > (1 << FAULT_W)) begin : g_bad_cfg
        $error("stage_sequencer: invalid parameter set");
    end

    typedef enum logic [1:0] {ST_CONTROL, ST_RUN, ST_HALT} state_e;
    typedef enum logic [1:0] {OP_TRAP = 2'b00, OP_EXT = 2'b01, OP_SW = 2'b10, OP_NORMAL = 2'b11} op_e;

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [IDX_W-1:0]      stage_q, stage_d;
    logic [FAULT_W:0]      cause_q, cause_d;
    logic                  flt_q, flt_d;
    logic [FAULT_W-1:0]    code_q, code_d;
    logic [NUM_STAGES-1:0] skip_q, skip_d;
    logic                  retired_q, retired_d;

    logic [NUM_STAGES-1:0] mask_eff;
    logic [IDX_W-1:0]      next_idx;
    logic                  next_found;
    logic                  irq_req;
    logic [FAULT_W-1:0]    irq_idx;
    logic                  run_fault;
    logic [FAULT_W-1:0]    run_code;
    logic [NUM_IRQ-1:0]    ack;

`ifdef STAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Lowest pending index wins; scan high to low so the last hit is the lowest.
    always_comb begin
        irq_req = 1'b0;
        irq_idx = '0;
        for (int unsigned k = NUM_IRQ; k > 0; k--) begin
            if (irq_pending[k-1]) begin
                irq_req = 1'b1;
                irq_idx = FAULT_W'(k - 1);
            end
        end
    end

    // External fault takes priority over the watchdog in the same cycle.
    always_comb begin
        run_fault = fault;
        run_code  = fault_code;
`ifdef STAGE_TIMEOUT_EN
        if (!fault && !stage_done[stage_q] && cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            run_fault = 1'b1;
            run_code  = '1;
        end
`endif
    end

    // Completion of the decode stage uses the freshly sampled mask for its own successor.
    always_comb begin
        mask_eff   = (stage_q == IDX_W'(SKIP_STAGE)) ? (stage_skip & KEEP_MASK) : skip_q;
        next_found = 1'b0;
        next_idx   = '0;
        for (int unsigned j = NUM_STAGES; j > 0; j--) begin
            if ((j - 1) > 32'(stage_q) && !mask_eff[j-1]) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(j - 1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        stage_d   = stage_q;
        cause_d   = cause_q;
        flt_d     = flt_q;
        code_d    = code_q;
        skip_d    = skip_q;
        retired_d = 1'b0;
        ack       = '0;
`ifdef STAGE_TIMEOUT_EN
        cnt_d     = '0;
`endif
        case (state_q)
            ST_CONTROL: begin
                skip_d = '0;
                if (flt_q) begin
                    op_d    = OP_TRAP;
                    cause_d = {1'b0, code_q};
                    flt_d   = 1'b0;
                end else if (irq_enable && irq_req) begin
                    op_d         = OP_EXT;
                    cause_d      = {1'b1, irq_idx};
                    ack[irq_idx] = 1'b1;
                end else begin
                    op_d = OP_NORMAL;
                end
                state_d = ST_RUN;
                stage_d = IDX_W'(1);
            end
            ST_RUN: begin
                if (run_fault) begin
                    if (op_q == OP_TRAP) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_CONTROL;
                        flt_d   = 1'b1;
                        code_d  = run_code;
                    end
                end else if (stage_done[stage_q]) begin
                    if (stage_q == IDX_W'(SKIP_STAGE)) begin
                        skip_d = mask_eff;
                    end
                    if (next_found) begin
                        stage_d = next_idx;
                    end else begin
                        state_d   = ST_CONTROL;
                        retired_d = (op_q == OP_NORMAL);
                    end
                end else begin
`ifdef STAGE_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CONTROL;
            op_q      <= OP_NORMAL;
            stage_q   <= '0;
            cause_q   <= '0;
            flt_q     <= 1'b0;
            code_q    <= '0;
            skip_q    <= '0;
            retired_q <= 1'b0;
`ifdef STAGE_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            stage_q   <= stage_d;
            cause_q   <= cause_d;
            flt_q     <= flt_d;
            code_q    <= code_d;
            skip_q    <= skip_d;
            retired_q <= retired_d;
`ifdef STAGE_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign stage_active  = (state_q == ST_RUN)     ? (NUM_STAGES'(1) << stage_q) :
                           (state_q == ST_CONTROL) ? NUM_STAGES'(1) : '0;
    assign control_op    = op_q;
    assign trap_cause    = cause_q;
    assign irq_ack       = ack;
    assign instr_retired = retired_q;
    assign halted        = (state_q == ST_HALT);

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;
    localparam int NS = 7;
    localparam int SK = 2;
    localparam int NI = 4;
    localparam int FW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NS-1:0] stage_done, stage_skip;
    logic          fault;
    logic [FW-1:0] fault_code;
    logic [NI-1:0] irq_pending;
    logic          irq_enable;
    logic [NS-1:0] stage_active;
    logic [1:0]    control_op;
    logic [FW:0]   trap_cause;
    logic [NI-1:0] irq_ack;
    logic          instr_retired;
    logic          halted;

    stage_sequencer #(.NUM_STAGES(NS), .SKIP_STAGE(SK), .NUM_IRQ(NI), .FAULT_W(FW), .TIMEOUT_CYC(255)) dut (
        .clk(clk), .reset(reset), .stage_done(stage_done), .stage_skip(stage_skip),
        .fault(fault), .fault_code(fault_code), .irq_pending(irq_pending), .irq_enable(irq_enable),
        .stage_active(stage_active), .control_op(control_op), .trap_cause(trap_cause),
        .irq_ack(irq_ack), .instr_retired(instr_retired), .halted(halted)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: mode 0 = CONTROL, 1 = running (q holds remaining stages, front active), 2 = halted.
    int          mode;
    int          q[$];
    logic [1:0]  m_op;
    logic [FW:0] m_cause;
    bit          m_fp;
    logic [FW-1:0] m_code;
    bit          m_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode = 0;
        q.delete();
        m_op = 2'b11;
        m_cause = '0;
        m_fp = 1'b0;
        m_code = '0;
        m_ret = 1'b0;
    endtask

    function automatic int lowest_irq();
        for (int k = 0; k < NI; k++) if (irq_pending[k]) return k;
        return -1;
    endfunction

    task automatic model_step();
        int cur;
        int t[$];
        if (reset) begin
            model_reset();
            return;
        end
        m_ret = 1'b0;
        if (mode == 0) begin
            if (m_fp) begin
                m_op = 2'b00;
                m_cause = {1'b0, m_code};
                m_fp = 1'b0;
            end else if (irq_enable && irq_pending != 0) begin
                m_op = 2'b01;
                m_cause = {1'b1, FW'(lowest_irq())};
            end else begin
                m_op = 2'b11;
            end
            q.delete();
            for (int s = 1; s < NS; s++) q.push_back(s);
            mode = 1;
        end else if (mode == 1) begin
            cur = q[0];
            if (fault) begin
                if (m_op == 2'b00) mode = 2;
                else begin
                    mode = 0;
                    m_fp = 1'b1;
                    m_code = fault_code;
                end
            end else if (stage_done[cur]) begin
                void'(q.pop_front());
                if (cur == SK) begin
                    foreach (q[i]) if (!stage_skip[q[i]]) t.push_back(q[i]);
                    q = t;
                end
                if (q.size() == 0) begin
                    mode = 0;
                    m_ret = (m_op == 2'b11);
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [NS-1:0] esa;
        logic [NI-1:0] eack;
        int k;
        esa = '0;
        eack = '0;
        if (mode == 0) esa = NS'(1);
        else if (mode == 1) esa = NS'(1) << q[0];
        if (mode == 0 && !m_fp && irq_enable) begin
            k = lowest_irq();
            if (k >= 0) eack = NI'(1) << k;
        end
        chk("stage_active", 32'(stage_active), 32'(esa));
        chk("control_op", 32'(control_op), 32'(m_op));
        chk("trap_cause", 32'(trap_cause), 32'(m_cause));
        chk("irq_ack", 32'(irq_ack), 32'(eack));
        chk("instr_retired", 32'(instr_retired), 32'(m_ret));
        chk("halted", 32'(halted), 32'(mode == 2));
    endtask

    task automatic set_in(input logic r, input logic [NS-1:0] d, input logic [NS-1:0] s,
                          input logic f, input logic [FW-1:0] c, input logic [NI-1:0] ip,
                          input logic en);
        reset = r;
        stage_done = d;
        stage_skip = s;
        fault = f;
        fault_code = c;
        irq_pending = ip;
        irq_enable = en;
        #1;
    endtask

    task automatic cyc(input bit do_cmp);
        if (do_cmp) compare_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    logic [NS-1:0] exp_list[7];

    initial begin
        model_reset();
        @(negedge clk);
        set_in(1'b1, '0, '0, 1'b0, '0, '0, 1'b0);
        cyc(1'b0);
        cyc(1'b0);

        // Reset state
        set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        chk("rst_stage_active", 32'(stage_active), 32'h1);
        chk("rst_control_op", 32'(control_op), 32'h3);
        chk("rst_trap_cause", 32'(trap_cause), 32'h0);
        chk("rst_irq_ack", 32'(irq_ack), 32'h0);
        chk("rst_retired", 32'(instr_retired), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);

        // Normal flow: 1,2,4,...,64 then back to CONTROL with retire
        set_in(1'b0, '1, '0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            chk("norm_seq", 32'(stage_active), 32'(1) << i);
            cyc(1'b1);
        end
        chk("norm_ret_sa", 32'(stage_active), 32'h1);
        chk("norm_retired", 32'(instr_retired), 32'h1);

        // Skip stage 5
        exp_list = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h40, 7'h01};
        set_in(1'b0, '1, 7'b0100000, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            chk("skip_seq", 32'(stage_active), 32'(exp_list[i]));
            if (i == 6) chk("skip_retired", 32'(instr_retired), 32'h1);
            cyc(1'b1);
        end

        // Fault in stage 4 with done also high
        set_in(1'b0, '1, '0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1);
        chk("flt_at_stage4", 32'(stage_active), 32'h10);
        set_in(1'b0, '1, '0, 1'b1, 3'd5, '0, 1'b0);
        cyc(1'b1);
        chk("flt_ctrl_sa", 32'(stage_active), 32'h1);
        chk("flt_no_retire", 32'(instr_retired), 32'h0);
        set_in(1'b0, '1, '0, 1'b0, '0, 4'b0110, 1'b1);
        chk("flt_no_ack", 32'(irq_ack), 32'h0);
        cyc(1'b1);
        chk("flt_op", 32'(control_op), 32'h0);
        chk("flt_cause", 32'(trap_cause), 32'h5);

        // Double fault during trap sequence
        set_in(1'b0, '0, '0, 1'b1, 3'd2, '0, 1'b0);
        cyc(1'b1);
        chk("df_halted", 32'(halted), 32'h1);
        chk("df_sa", 32'(stage_active), 32'h0);
        set_in(1'b0, '1, '0, 1'b0, '0, 4'b0001, 1'b1);
        cyc(1'b1);
        chk("df_hold", 32'(halted), 32'h1);
        set_in(1'b1, '0, '0, 1'b0, '0, '0, 1'b0);
        cyc(1'b0);
        set_in(1'b0, '1, '0, 1'b0, '0, 4'b0110, 1'b1);
        chk("df_reset_sa", 32'(stage_active), 32'h1);

        // Interrupt accepted in CONTROL
        chk("irq_ack_pulse", 32'(irq_ack), 32'h2);
        cyc(1'b1);
        chk("irq_op", 32'(control_op), 32'h1);
        chk("irq_cause", 32'(trap_cause), 32'h9);
        chk("irq_ack_gone", 32'(irq_ack), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            set_in(($urandom_range(0, 299) == 0),
                   ($urandom_range(0, 9) < 6) ? '1 : NS'($urandom),
                   NS'($urandom),
                   ($urandom_range(0, 24) == 0),
                   FW'($urandom),
                   ($urandom_range(0, 2) == 0) ? NI'($urandom) : '0,
                   1'($urandom));
            cyc(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
